// File: rtl/risc_ctrl_pkg.sv
// risc_ctrl_pkg: shared state encoding and default sizing for the run controller.
package risc_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HOLD,
    RUN,
    DONE,
    TMO
  } state_t;

  localparam int unsigned WORD_W             = 16;
  localparam int unsigned DEF_PROG_DEPTH     = 8;
  localparam int unsigned DEF_ADDR_W         = 3;
  localparam int unsigned DEF_RST_CYCLES     = 2;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;
  localparam int unsigned DEF_CNT_W          = 16;

endpackage

// File: rtl/risc_run_ctrl_if.sv
// risc_run_ctrl_if: program-load stream from the host into the run controller.
interface risc_run_ctrl_if;
  import risc_ctrl_pkg::*;

  logic              ld_valid;
  logic [WORD_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;

  modport master (output ld_valid, output ld_data, output ld_last, input ld_ready);
  modport slave  (input ld_valid, input ld_data, input ld_last, output ld_ready);

endinterface

// File: rtl/risc_trace_fifo.sv
// risc_trace_fifo: generic 4-entry synchronous FIFO; push when full and pop when
// empty are ignored. clr empties it synchronously.
module risc_trace_fifo #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic         full
);

  logic [W-1:0] mem [4];
  logic [1:0]   rd_ptr;
  logic [1:0]   wr_ptr;
  logic [2:0]   count;
  logic         do_push;
  logic         do_pop;

  assign valid   = (count != 3'd0);
  assign full    = (count == 3'd4);
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && valid;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, do_push} - {2'b00, do_pop};
    end
  end

endmodule

// File: rtl/risc_run_ctrl.sv
// risc_run_ctrl: loads a program into the core's instruction memory, holds the
// PC in reset, releases the core and supervises it until HLT or timeout.
// Build option OUTR_TRACE_EN adds a 4-deep trace FIFO of OutR changes during RUN.
module risc_run_ctrl
  import risc_ctrl_pkg::*;
#(
  parameter int unsigned PROG_DEPTH     = DEF_PROG_DEPTH,
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned RST_CYCLES     = DEF_RST_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  risc_run_ctrl_if.slave    ld,
  output logic [WORD_W-1:0] core_ext_data,
  output logic              core_ext_we,
  output logic [ADDR_W-1:0] core_ld_addr,
  output logic              core_pc_rst,
  input  logic              core_done,
  input  logic [WORD_W-1:0] core_outr,
  output logic              busy,
  output logic              finished,
  output logic              timeout,
  output logic [WORD_W-1:0] result,
  output logic [CNT_W-1:0]  cycles
`ifdef OUTR_TRACE_EN
  ,
  output logic              trace_valid,
  output logic [WORD_W-1:0] trace_data,
  input  logic              trace_pop,
  output logic              trace_ovf
`endif
);

  localparam int unsigned       HOLD_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(PROG_DEPTH - 1);
  localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state;
  state_t            state_nxt;
  logic              start_go;
  logic              xfer;
  logic [ADDR_W-1:0] addr;
  logic [HOLD_W-1:0] hold_cnt;

  assign start_go      = start && (state inside {IDLE, DONE, TMO});
  assign xfer          = ld.ld_ready && ld.ld_valid;
  assign core_ext_we   = xfer;
  assign core_ext_data = xfer ? ld.ld_data : '0;
  assign core_ld_addr  = addr;

  // Next-state selection; halt wins over timeout in the same RUN cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, TMO: if (start_go) state_nxt = LOAD;
      LOAD:            if (xfer && (ld.ld_last || addr == ADDR_LAST)) state_nxt = HOLD;
      HOLD:            if (hold_cnt == HOLD_LAST) state_nxt = RUN;
      RUN: begin
        if (core_done)              state_nxt = DONE;
        else if (cycles == TMO_LAST) state_nxt = TMO;
      end
      default:         state_nxt = IDLE;
    endcase
  end

  // State, counters and status flags; flags are decoded from the next state so they are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      addr        <= '0;
      hold_cnt    <= '0;
      cycles      <= '0;
      result      <= '0;
      ld.ld_ready <= 1'b0;
      core_pc_rst <= 1'b1;
      busy        <= 1'b0;
      finished    <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_nxt;
      ld.ld_ready <= (state_nxt == LOAD);
      core_pc_rst <= !(state_nxt inside {RUN, DONE});
      busy        <= (state_nxt inside {LOAD, HOLD, RUN});
      finished    <= (state_nxt == DONE);
      timeout     <= (state_nxt == TMO);
      hold_cnt    <= (state == HOLD) ? hold_cnt + 1'b1 : '0;
      if (start_go) begin
        addr   <= '0;
        cycles <= '0;
      end else begin
        if (xfer) addr <= addr + 1'b1;
        if (state == RUN && cycles != '1) cycles <= cycles + 1'b1;
      end
      if (state == RUN && core_done) result <= core_outr;
    end
  end

`ifdef OUTR_TRACE_EN
  logic [WORD_W-1:0] last_outr;
  logic              trace_push;
  logic              trace_full;

  assign trace_push = (state == RUN) && (core_outr != last_outr);

  // Previous OutR for change detection; overflow stays set until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_outr <= '0;
      trace_ovf <= 1'b0;
    end else begin
      last_outr <= core_outr;
      if (start_go)                       trace_ovf <= 1'b0;
      else if (trace_push && trace_full)  trace_ovf <= 1'b1;
    end
  end

  risc_trace_fifo #(.W(WORD_W)) u_trace (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_go),
    .push  (trace_push),
    .din   (core_outr),
    .pop   (trace_pop),
    .valid (trace_valid),
    .dout  (trace_data),
    .full  (trace_full)
  );
`endif

endmodule

// File: tb/tb_risc_run_ctrl.sv
// tb_risc_run_ctrl: table vectors, directed corner sequences and randomized
// load/run transactions checked against a transaction-level expectation.
module tb_risc_run_ctrl;
  import risc_ctrl_pkg::*;

  localparam int unsigned TO   = 48;
  localparam int unsigned RSTC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        core_done;
  logic [15:0] core_outr;
  logic [15:0] core_ext_data;
  logic        core_ext_we;
  logic [2:0]  core_ld_addr;
  logic        core_pc_rst;
  logic        busy;
  logic        finished;
  logic        timeout;
  logic [15:0] result;
  logic [15:0] cycles;
`ifdef OUTR_TRACE_EN
  logic        trace_valid;
  logic [15:0] trace_data;
  logic        trace_pop;
  logic        trace_ovf;
`endif

  risc_run_ctrl_if ld_if ();

  risc_run_ctrl #(
    .PROG_DEPTH     (8),
    .ADDR_W         (3),
    .RST_CYCLES     (RSTC),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .ld            (ld_if),
    .core_ext_data (core_ext_data),
    .core_ext_we   (core_ext_we),
    .core_ld_addr  (core_ld_addr),
    .core_pc_rst   (core_pc_rst),
    .core_done     (core_done),
    .core_outr     (core_outr),
    .busy          (busy),
    .finished      (finished),
    .timeout       (timeout),
    .result        (result),
    .cycles        (cycles)
`ifdef OUTR_TRACE_EN
    ,
    .trace_valid   (trace_valid),
    .trace_data    (trace_data),
    .trace_pop     (trace_pop),
    .trace_ovf     (trace_ovf)
`endif
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned passes = 0;
  logic [15:0] exp_res = 16'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    #1;
    check("start.idle_busy", busy, 1'b0);
    step();
    start = 1'b0;
    check("start.ready", ld_if.ld_ready, 1'b1);
    check("start.fin", finished, 1'b0);
    check("start.tmo", timeout, 1'b0);
    check("start.cycles", cycles, 16'h0);
  endtask

  // One complete program load and run, predicted from the behavioural rules.
  task automatic run_txn(input int unsigned nwords, input bit use_last, input int unsigned last_idx,
                         input int unsigned done_at, input logic [15:0] outr_val, input bit poke);
    logic [15:0] words[$];
    int unsigned n_exp, acc, idx, guard, hold, k, run_len;
    bit v;
    for (int unsigned i = 0; i < nwords; i++) words.push_back(16'($urandom));
    n_exp = use_last ? last_idx + 1 : nwords;
    if (n_exp > 8) n_exp = 8;
    run_len = (done_at <= TO) ? done_at : TO;

    pulse_start();
    acc = 0; idx = 0; guard = 0;
    while (acc < n_exp && guard < 200) begin
      guard++;
      v = ($urandom_range(0, 3) != 0);
      ld_if.ld_valid = v;
      ld_if.ld_data  = v ? words[idx] : 16'h0;
      ld_if.ld_last  = v && use_last && (idx == last_idx);
      #1;
      check("load.ready", ld_if.ld_ready, 1'b1);
      check("load.we", core_ext_we, v);
      if (v) begin
        check($sformatf("load.addr%0d", acc), core_ld_addr, acc);
        check($sformatf("load.data%0d", acc), core_ext_data, words[idx]);
        acc++; idx++;
      end
      step();
    end
    check("load.count", acc, n_exp);

    ld_if.ld_valid = (idx < nwords);
    ld_if.ld_data  = (idx < nwords) ? words[idx] : 16'h0;
    ld_if.ld_last  = 1'b0;
    #1;
    check("hold.ready", ld_if.ld_ready, 1'b0);
    check("hold.we", core_ext_we, 1'b0);
    check("hold.pcr", core_pc_rst, 1'b1);
    check("hold.busy", busy, 1'b1);
    hold = 0;
    while (busy && core_pc_rst && hold < 20) begin
      hold++;
      if (poke && hold == 1) start = 1'b1;
      step();
      start = 1'b0;
      ld_if.ld_valid = 1'b0;
    end
    check("hold.len", hold, RSTC);

    k = 0;
    while (busy && !core_pc_rst && k < TO + 10) begin
      k++;
      check("run.cycles", cycles, k - 1);
      core_outr = 16'($urandom);
      if (k == done_at) begin
        core_done = 1'b1;
        core_outr = outr_val;
      end
      if (poke && k == 3) start = 1'b1;
      step();
      core_done = 1'b0;
      start     = 1'b0;
    end
    check("run.len", k, run_len);
    if (done_at <= TO) exp_res = outr_val;
    check("end.fin", finished, done_at <= TO);
    check("end.tmo", timeout, done_at > TO);
    check("end.pcr", core_pc_rst, done_at > TO);
    check("end.busy", busy, 1'b0);
    check("end.result", result, exp_res);
    check("end.cycles", cycles, run_len);
    step();
    check("end.cycles_frozen", cycles, run_len);
    check("end.result_kept", result, exp_res);
  endtask

  typedef struct {
    logic        st, vl;
    logic [15:0] dt;
    logic        ls, dn;
    logic [15:0] ou;
    logic        e_rdy, e_we;
    logic [2:0]  e_addr;
    logic [15:0] e_data;
    logic        e_pcr, e_busy, e_fin, e_tmo;
    logic [15:0] e_res, e_cyc;
  } vec_t;

  vec_t vt[10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; core_done = 1'b0; core_outr = 16'h0;
    ld_if.ld_valid = 1'b0; ld_if.ld_data = 16'h0; ld_if.ld_last = 1'b0;
`ifdef OUTR_TRACE_EN
    trace_pop = 1'b0;
`endif
    step(); step();
    check("rst.ready", ld_if.ld_ready, 1'b0);
    check("rst.we", core_ext_we, 1'b0);
    check("rst.data", core_ext_data, 16'h0);
    check("rst.addr", core_ld_addr, 3'd0);
    check("rst.pcr", core_pc_rst, 1'b1);
    check("rst.busy", busy, 1'b0);
    check("rst.fin", finished, 1'b0);
    check("rst.tmo", timeout, 1'b0);
    check("rst.result", result, 16'h0);
    check("rst.cycles", cycles, 16'h0);
    rst = 1'b0;
    step();

    //        st vl  data     ls dn outr      rdy we addr data     pcr bsy fin tmo res      cyc
    vt[0] = '{1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 3'd0, 16'h0000, 1, 0, 0, 0, 16'h0000, 16'd0};
    vt[1] = '{0, 1, 16'h1234, 0, 0, 16'h0000, 1, 1, 3'd0, 16'h1234, 1, 1, 0, 0, 16'h0000, 16'd0};
    vt[2] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 3'd1, 16'h0000, 1, 1, 0, 0, 16'h0000, 16'd0};
    vt[3] = '{0, 1, 16'h5678, 0, 0, 16'h0000, 1, 1, 3'd1, 16'h5678, 1, 1, 0, 0, 16'h0000, 16'd0};
    vt[4] = '{0, 1, 16'h9ABC, 1, 0, 16'h0000, 1, 1, 3'd2, 16'h9ABC, 1, 1, 0, 0, 16'h0000, 16'd0};
    vt[5] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 3'd3, 16'h0000, 1, 1, 0, 0, 16'h0000, 16'd0};
    vt[6] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 3'd3, 16'h0000, 1, 1, 0, 0, 16'h0000, 16'd0};
    vt[7] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 3'd3, 16'h0000, 0, 1, 0, 0, 16'h0000, 16'd0};
    vt[8] = '{0, 0, 16'h0000, 0, 1, 16'h00A5, 0, 0, 3'd3, 16'h0000, 0, 1, 0, 0, 16'h0000, 16'd1};
    vt[9] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 3'd3, 16'h0000, 0, 0, 1, 0, 16'h00A5, 16'd2};

    for (int i = 0; i < 10; i++) begin
      start = vt[i].st; ld_if.ld_valid = vt[i].vl; ld_if.ld_data = vt[i].dt;
      ld_if.ld_last = vt[i].ls; core_done = vt[i].dn; core_outr = vt[i].ou;
      #1;
      check($sformatf("vec%0d.ready", i), ld_if.ld_ready, vt[i].e_rdy);
      check($sformatf("vec%0d.we", i), core_ext_we, vt[i].e_we);
      check($sformatf("vec%0d.addr", i), core_ld_addr, vt[i].e_addr);
      check($sformatf("vec%0d.data", i), core_ext_data, vt[i].e_data);
      check($sformatf("vec%0d.pcr", i), core_pc_rst, vt[i].e_pcr);
      check($sformatf("vec%0d.busy", i), busy, vt[i].e_busy);
      check($sformatf("vec%0d.fin", i), finished, vt[i].e_fin);
      check($sformatf("vec%0d.tmo", i), timeout, vt[i].e_tmo);
      check($sformatf("vec%0d.result", i), result, vt[i].e_res);
      check($sformatf("vec%0d.cycles", i), cycles, vt[i].e_cyc);
      step();
    end
    start = 1'b0; core_done = 1'b0; ld_if.ld_valid = 1'b0; ld_if.ld_last = 1'b0;
    exp_res = 16'h00A5;

    // 10 words, no ld_last: only 8 accepted; halt on run cycle 37.
    run_txn(10, 1'b0, 0, 37, 16'h00A5, 1'b0);
    // Never halts: timeout after TO run cycles, result kept.
    run_txn(1, 1'b1, 0, TO + 100, 16'h5555, 1'b0);

    // Reset in the middle of a load, after two writes.
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      ld_if.ld_valid = 1'b1; ld_if.ld_data = 16'hC000 + 16'(i); ld_if.ld_last = 1'b0;
      #1;
      check("abort.addr", core_ld_addr, i);
      step();
    end
    rst = 1'b1;
    #1;
    check("abort.ready", ld_if.ld_ready, 1'b0);
    check("abort.we", core_ext_we, 1'b0);
    check("abort.addr0", core_ld_addr, 3'd0);
    check("abort.pcr", core_pc_rst, 1'b1);
    check("abort.busy", busy, 1'b0);
    check("abort.result", result, 16'h0);
    check("abort.cycles", cycles, 16'h0);
    exp_res = 16'h0;
    ld_if.ld_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    run_txn(3, 1'b1, 2, 5, 16'h0F0F, 1'b0);

    for (int t = 0; t < 25; t++) begin
      int unsigned nw, li;
      bit ul;
      nw = $urandom_range(1, 10);
      ul = (nw < 8) ? 1'b1 : 1'($urandom_range(0, 1));
      li = ul ? $urandom_range(0, nw - 1) : 0;
      run_txn(nw, ul, li, $urandom_range(1, TO + 5), 16'($urandom), 1'($urandom_range(0, 1)));
    end

`ifdef OUTR_TRACE_EN
    begin
      int unsigned g;
      core_outr = 16'h0;
      pulse_start();
      ld_if.ld_valid = 1'b1; ld_if.ld_data = 16'h7777; ld_if.ld_last = 1'b1;
      step();
      ld_if.ld_valid = 1'b0; ld_if.ld_last = 1'b0;
      g = 0;
      while (core_pc_rst && g < 20) begin
        g++;
        step();
      end
      check("trace.in_run", busy && !core_pc_rst, 1'b1);
      for (int v = 1; v <= 5; v++) begin
        core_outr = 16'(v);
        step();
      end
      core_done = 1'b1;
      step();
      core_done = 1'b0;
      check("trace.ovf", trace_ovf, 1'b1);
      for (int v = 1; v <= 4; v++) begin
        check("trace.valid", trace_valid, 1'b1);
        check($sformatf("trace.data%0d", v), trace_data, v);
        trace_pop = 1'b1;
        step();
        trace_pop = 1'b0;
      end
      check("trace.empty", trace_valid, 1'b0);
      trace_pop = 1'b1;
      step();
      trace_pop = 1'b0;
      check("trace.empty_pop", trace_valid, 1'b0);
      start = 1'b1;
      step();
      start = 1'b0;
      check("trace.ovf_clr", trace_ovf, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
    end
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
